el2_lsu_clkgate_ctrl: RTL and testbench

- Sequences the LSU clock-enable domain.
- Keeps the LSU free clock enabled for a fixed hysteresis window after activity stops, then gates it.
- Runs a halt quiesce/ack handshake with the TLU and produces the pipe double-pulse enable.
- Feeds the enables consumed by the LSU clock headers; counts gated cycles for power/perf reporting.

---
 rtl/el2_lsu_clkgate_ctrl_if.sv | 33 +++
 rtl/el2_lsu_clkgate_ctrl.sv | 117 +++++++++++
 tb/tb_el2_lsu_clkgate_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/el2_lsu_clkgate_ctrl_if.sv
// Signal bundle between the LSU/TLU side and the LSU clock-gating controller.
// The master drives status and requests; the slave returns the clock enables and halt status.
interface el2_lsu_clkgate_ctrl_if #(
  parameter int GCNT_W = 16
);
  logic              lsu_activity;
  logic              lsu_idle;
  logic              lsu_p_valid;
  logic              dma_dccm_req;
  logic              clk_override;
  logic              halt_req;
  logic              dec_tlu_force_halt;
  logic              lsu_free_clken;
  logic              lsu_pipe_c1_clken;
  logic              lsu_pipe_c2_clken;
  logic              lsu_halt_ack;
  logic [2:0]        lsu_gate_state;
  logic [GCNT_W-1:0] lsu_gated_cycles;

  modport master (
    output lsu_activity, lsu_idle, lsu_p_valid, dma_dccm_req, clk_override,
           halt_req, dec_tlu_force_halt,
    input  lsu_free_clken, lsu_pipe_c1_clken, lsu_pipe_c2_clken, lsu_halt_ack,
           lsu_gate_state, lsu_gated_cycles
  );

  modport slave (
    input  lsu_activity, lsu_idle, lsu_p_valid, dma_dccm_req, clk_override,
           halt_req, dec_tlu_force_halt,
    output lsu_free_clken, lsu_pipe_c1_clken, lsu_pipe_c2_clken, lsu_halt_ack,
           lsu_gate_state, lsu_gated_cycles
  );
endinterface

// File: rtl/el2_lsu_clkgate_ctrl.sv
// LSU clock-enable sequencer: idle hysteresis before gating the free clock,
// TLU halt quiesce/ack handshake, pipe double-pulse enable and gated-cycle counter.
//
// state   | meaning
// RUN     | LSU active, free clock on
// HOLD    | no activity, hysteresis countdown with free clock still on
// GATED   | free clock off, woken combinationally by activity
// QUIESCE | halt requested, waiting for LSU idle and no DMA
// HALTED  | LSU halted, ack high, clock only for DMA
module el2_lsu_clkgate_ctrl #(
  parameter int IDLE_HOLD = 4,
  parameter int CNT_W     = 3,
  parameter int GCNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst_l,
  el2_lsu_clkgate_ctrl_if.slave lsu
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_HOLD    = 3'd1,
    ST_GATED   = 3'd2,
    ST_QUIESCE = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  localparam int               HOLD_INT  = (IDLE_HOLD == 0) ? 0 : IDLE_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_INT);
  localparam bit               NO_HOLD   = (IDLE_HOLD == 0);

  state_t            state_q, state_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              ack_q;
  logic              pipe_q;
  logic [GCNT_W-1:0] gcnt_q;
  logic              free_clken;
  logic              c1_clken;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      pipe_q  <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      ack_q   <= (state_nx == ST_HALTED);
      pipe_q  <= c1_clken;
      if (!free_clken && (gcnt_q != {GCNT_W{1'b1}}))
        gcnt_q <= gcnt_q + GCNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    if (lsu.dec_tlu_force_halt) begin
      state_nx = ST_HALTED;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lsu.halt_req) begin
            state_nx = ST_QUIESCE;
          end else if (!lsu.lsu_activity) begin
            if (NO_HOLD) begin
              state_nx = ST_GATED;
            end else begin
              state_nx = ST_HOLD;
              cnt_nx   = HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (lsu.halt_req)          state_nx = ST_QUIESCE;
          else if (lsu.lsu_activity) state_nx = ST_RUN;
          else if (cnt_q == '0)      state_nx = ST_GATED;
          else                       cnt_nx   = cnt_q - CNT_W'(1);
        end
        ST_GATED: begin
          if (lsu.halt_req)          state_nx = ST_QUIESCE;
          else if (lsu.lsu_activity) state_nx = ST_RUN;
        end
        ST_QUIESCE: begin
          if (!lsu.halt_req)                             state_nx = ST_RUN;
          else if (lsu.lsu_idle && !lsu.dma_dccm_req)    state_nx = ST_HALTED;
        end
        ST_HALTED: begin
          if (!lsu.halt_req) state_nx = ST_RUN;
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

  // Enables stay combinational so a wake from GATED costs no cycle.
  always_comb begin
    free_clken = 1'b1;
    case (state_q)
      ST_GATED:  free_clken = lsu.lsu_activity | lsu.clk_override;
      ST_HALTED: free_clken = lsu.dma_dccm_req | lsu.clk_override;
      default:   free_clken = 1'b1;
    endcase
  end

  assign c1_clken = lsu.lsu_p_valid | lsu.dma_dccm_req | lsu.clk_override;

  assign lsu.lsu_free_clken    = free_clken;
  assign lsu.lsu_pipe_c1_clken = c1_clken;
  assign lsu.lsu_pipe_c2_clken = c1_clken | pipe_q | lsu.clk_override;
  assign lsu.lsu_halt_ack      = ack_q;
  assign lsu.lsu_gate_state    = state_q;
  assign lsu.lsu_gated_cycles  = gcnt_q;

endmodule

// File: tb/tb_el2_lsu_clkgate_ctrl.sv
// Bench for el2_lsu_clkgate_ctrl: vector table through a scoreboard queue on a
// GCNT_W=16 and a GCNT_W=4 instance, plus hand sequences for reset and IDLE_HOLD=0.
module tb_el2_lsu_clkgate_ctrl;

  logic clk;
  logic rst_l;

  el2_lsu_clkgate_ctrl_if #(.GCNT_W(16)) if_m ();
  el2_lsu_clkgate_ctrl_if #(.GCNT_W(4))  if_s ();
  el2_lsu_clkgate_ctrl_if #(.GCNT_W(16)) if_z ();

  el2_lsu_clkgate_ctrl #(.IDLE_HOLD(4), .CNT_W(3), .GCNT_W(16)) u_m (.clk(clk), .rst_l(rst_l), .lsu(if_m));
  el2_lsu_clkgate_ctrl #(.IDLE_HOLD(4), .CNT_W(3), .GCNT_W(4))  u_s (.clk(clk), .rst_l(rst_l), .lsu(if_s));
  el2_lsu_clkgate_ctrl #(.IDLE_HOLD(0), .CNT_W(3), .GCNT_W(16)) u_z (.clk(clk), .rst_l(rst_l), .lsu(if_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic act, idle, pv, dma, ovr, hreq, fh;
    logic [2:0] st;
    logic free, c1, c2, ack;
    logic [15:0] gm;
    logic [3:0]  gs;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   gcnt  = 0;

  task automatic v(input logic act, idle, pv, dma, ovr, hreq, fh,
                   input logic [2:0] st, input logic free, c1, c2, ack);
    vec_t r;
    r.act = act; r.idle = idle; r.pv = pv; r.dma = dma; r.ovr = ovr; r.hreq = hreq; r.fh = fh;
    r.st = st; r.free = free; r.c1 = c1; r.c2 = c2; r.ack = ack;
    r.gm = '0; r.gs = '0;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, got, want);
    end
  endtask

  task automatic drive(input vec_t r);
    vec_t e;
    if_m.lsu_activity = r.act;  if_s.lsu_activity = r.act;
    if_m.lsu_idle     = r.idle; if_s.lsu_idle     = r.idle;
    if_m.lsu_p_valid  = r.pv;   if_s.lsu_p_valid  = r.pv;
    if_m.dma_dccm_req = r.dma;  if_s.dma_dccm_req = r.dma;
    if_m.clk_override = r.ovr;  if_s.clk_override = r.ovr;
    if_m.halt_req     = r.hreq; if_s.halt_req     = r.hreq;
    if_m.dec_tlu_force_halt = r.fh; if_s.dec_tlu_force_halt = r.fh;
    e = r;
    e.gm = 16'(gcnt);
    e.gs = (gcnt > 15) ? 4'hf : 4'(gcnt);
    if (!r.free) gcnt++;
    exp_q.push_back(e);
  endtask

  task automatic sample(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", idx, 16'd0, 16'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("state",     idx, 16'(if_m.lsu_gate_state),    16'(e.st));
    chk("free",      idx, 16'(if_m.lsu_free_clken),    16'(e.free));
    chk("c1",        idx, 16'(if_m.lsu_pipe_c1_clken), 16'(e.c1));
    chk("c2",        idx, 16'(if_m.lsu_pipe_c2_clken), 16'(e.c2));
    chk("ack",       idx, 16'(if_m.lsu_halt_ack),      16'(e.ack));
    chk("gated",     idx, if_m.lsu_gated_cycles,       e.gm);
    chk("gated_sat", idx, 16'(if_s.lsu_gated_cycles),  16'(e.gs));
    chk("state_sat", idx, 16'(if_s.lsu_gate_state),    16'(e.st));
  endtask

  task automatic z_in(input logic act);
    if_z.lsu_activity = act; if_z.lsu_idle = 1'b1; if_z.lsu_p_valid = 1'b0;
    if_z.dma_dccm_req = 1'b0; if_z.clk_override = 1'b0;
    if_z.halt_req = 1'b0; if_z.dec_tlu_force_halt = 1'b0;
  endtask

  initial begin
    vec_t idle_v;
    //  act idle pv dma ovr hreq fh | st free c1 c2 ack
    v(1,1,0,0,0,0,0, 0,1,0,0,0);  // 0 activity
    v(0,1,0,0,0,0,0, 0,1,0,0,0);  // 1 last RUN cycle
    v(0,1,0,0,0,0,0, 1,1,0,0,0);  // 2 HOLD cnt3
    v(0,1,0,0,0,0,0, 1,1,0,0,0);
    v(0,1,0,0,0,0,0, 1,1,0,0,0);
    v(0,1,0,0,0,0,0, 1,1,0,0,0);  // 5 HOLD cnt0
    v(0,1,0,0,0,0,0, 2,0,0,0,0);  // 6 gated
    v(1,1,0,0,0,0,0, 2,1,0,0,0);  // 7 zero-cycle wake
    v(1,1,1,0,0,0,0, 0,1,1,1,0);  // 8 pkt valid
    v(1,1,0,0,0,0,0, 0,1,0,1,0);  // 9 c2 stretch
    v(1,1,0,0,0,0,0, 0,1,0,0,0);
    v(1,0,0,0,0,1,0, 0,1,0,0,0);  // 11 halt_req, busy
    v(0,0,0,0,0,1,0, 3,1,0,0,0);
    v(0,0,0,0,0,1,0, 3,1,0,0,0);
    v(0,1,0,0,0,1,0, 3,1,0,0,0);  // 14 idle -> HALTED
    v(0,1,0,0,0,1,0, 4,0,0,0,1);
    v(0,1,0,1,0,1,0, 4,1,1,1,1);  // 16 DMA while halted
    v(0,1,0,0,0,1,0, 4,0,0,1,1);
    v(0,1,0,0,0,0,0, 4,0,0,0,1);  // 18 release halt
    v(1,1,0,0,0,0,0, 0,1,0,0,0);
    v(0,1,0,0,0,0,0, 0,1,0,0,0);  // 20
    v(0,1,0,0,0,0,0, 1,1,0,0,0);  // HOLD cnt3
    v(0,1,0,0,0,0,1, 1,1,0,0,0);  // 22 force halt at cnt2
    v(0,1,0,0,0,0,0, 4,0,0,0,1);
    v(1,1,0,0,0,0,0, 0,1,0,0,0);
    v(1,1,0,0,0,1,1, 0,1,0,0,0);  // 25 force + halt_req
    v(0,1,0,0,0,0,1, 4,0,0,0,1);  // force holds HALTED
    v(1,1,0,0,0,0,0, 4,0,0,0,1);
    v(1,1,0,0,0,0,0, 0,1,0,0,0);
    v(1,0,0,0,0,1,0, 0,1,0,0,0);  // 29 quiesce then abort
    v(1,0,0,0,0,0,0, 3,1,0,0,0);
    v(1,1,0,0,0,0,0, 0,1,0,0,0);
    v(0,1,0,1,0,1,0, 0,1,1,1,0);  // 32 DMA blocks quiesce
    v(0,1,0,1,0,1,0, 3,1,1,1,0);
    v(0,1,0,0,0,1,0, 3,1,0,1,0);
    v(0,1,0,0,0,0,0, 4,0,0,0,1);
    v(0,1,0,0,0,0,0, 0,1,0,0,0);  // 36
    v(0,1,0,0,0,0,0, 1,1,0,0,0);
    v(0,1,0,0,0,0,0, 1,1,0,0,0);
    v(0,1,0,0,0,0,0, 1,1,0,0,0);
    v(0,1,0,0,0,0,0, 1,1,0,0,0);
    v(0,1,0,0,0,0,0, 2,0,0,0,0);  // 41
    v(0,1,0,0,1,0,0, 2,1,1,1,0);  // 42 override in GATED
    v(0,1,0,0,1,0,0, 2,1,1,1,0);
    v(0,1,0,0,0,0,0, 2,0,0,1,0);
    v(1,1,0,0,0,0,0, 2,1,0,0,0);
    v(1,1,0,0,0,0,0, 0,1,0,0,0);  // 46
    v(0,1,0,0,0,0,0, 0,1,0,0,0);
    for (int i = 0; i < 4; i++)  v(0,1,0,0,0,0,0, 1,1,0,0,0);
    for (int i = 0; i < 20; i++) v(0,1,0,0,0,0,0, 2,0,0,0,0);  // long gate: saturates GCNT_W=4
    v(1,1,0,0,0,0,0, 2,1,0,0,0);
    v(1,1,0,0,0,0,0, 0,1,0,0,0);

    idle_v = vecs[1];
    rst_l = 1'b0;
    drive(idle_v);
    void'(exp_q.pop_front());
    z_in(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", -1, 16'(if_m.lsu_gate_state),  16'd0);
    chk("rst_ack",   -1, 16'(if_m.lsu_halt_ack),    16'd0);
    chk("rst_gated", -1, if_m.lsu_gated_cycles,     16'd0);
    chk("rst_c2",    -1, 16'(if_m.lsu_pipe_c2_clken), 16'd0);
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      sample(i);
      @(negedge clk);
    end

    // Asynchronous reset while HALTED.
    idle_v.fh = 1'b1;
    drive(idle_v);
    void'(exp_q.pop_front());
    @(negedge clk);
    idle_v.fh = 1'b0;
    drive(idle_v);
    void'(exp_q.pop_front());
    #1;
    chk("halt_pre_rst_state", 100, 16'(if_m.lsu_gate_state), 16'd4);
    chk("halt_pre_rst_ack",   100, 16'(if_m.lsu_halt_ack),   16'd1);
    #1 rst_l = 1'b0;
    #1;
    chk("halt_rst_state", 101, 16'(if_m.lsu_gate_state),   16'd0);
    chk("halt_rst_ack",   101, 16'(if_m.lsu_halt_ack),     16'd0);
    chk("halt_rst_gated", 101, if_m.lsu_gated_cycles,      16'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // IDLE_HOLD=0: RUN with no activity gates after one edge.
    @(negedge clk);
    #1;
    chk("z_gated_state", 200, 16'(if_z.lsu_gate_state), 16'd2);
    chk("z_gated_free",  200, 16'(if_z.lsu_free_clken), 16'd0);
    z_in(1'b1);
    #1;
    chk("z_wake_free",   201, 16'(if_z.lsu_free_clken), 16'd1);
    @(negedge clk);
    z_in(1'b0);
    #1;
    chk("z_run_state",   202, 16'(if_z.lsu_gate_state), 16'd0);
    @(negedge clk);
    #1;
    chk("z_regate_state", 203, 16'(if_z.lsu_gate_state), 16'd2);
    chk("z_regate_free",  203, 16'(if_z.lsu_free_clken), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
